sudoku_board_dp: RTL and testbench



---
 rtl/sudoku_pkg.sv | 46 ++++
 rtl/sudoku_group_check.sv | 34 +++
 rtl/sudoku_board_dp.sv | 195 +++++++++++++++++++
 tb/tb_sudoku_board_dp.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and elaboration-time helpers for the Sudoku board datapath.
// group_cell maps (group, member) to a row-major cell index for any box size.
package sudoku_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK
    } state_t;

    function automatic int vw_of(input int box);
        return $clog2(box * box + 1);
    endfunction

    function automatic int iw_of(input int box);
        return $clog2(box * box * box * box);
    endfunction

    function automatic int ew_of(input int box);
        return $clog2(3 * box * box + 1);
    endfunction

    // Groups 0..N-1 are rows, N..2N-1 columns, 2N..3N-1 boxes (row-major).
    function automatic int unsigned group_cell(input int unsigned box,
                                               input int unsigned g,
                                               input int unsigned k);
        int unsigned n;
        int unsigned b;
        int unsigned r;
        int unsigned c;
        n = box * box;
        if (g < n) begin
            r = g;
            c = k;
        end else if (g < 2 * n) begin
            r = k;
            c = g - n;
        end else begin
            b = g - 2 * n;
            r = (b / box) * box + k / box;
            c = (b % box) * box + k % box;
        end
        return r * n + c;
    endfunction

endpackage

// File: rtl/sudoku_group_check.sv
// Combinational check of one Sudoku group (row, column or box) of N cells.
// dup: some nonzero digit occurs twice; full: no blank cell in the group.
module sudoku_group_check
    import sudoku_pkg::*;
#(
    parameter  int BOX = 2,
    localparam int N   = BOX * BOX,
    localparam int VW  = vw_of(BOX)
) (
    input  logic [N*VW-1:0] vals,
    output logic            dup,
    output logic            full
);

    logic [(1<<VW)-1:0] seen;
    logic [VW-1:0]      v;

    always_comb begin
        seen = '0;
        dup  = 1'b0;
        full = 1'b1;
        v    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            v = vals[k*VW +: VW];
            if (v == '0) begin
                full = 1'b0;
            end else begin
                if (seen[v]) dup = 1'b1;
                seen[v] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sudoku_board_dp.sv
// Sudoku board datapath: board/given-mask storage, puzzle load, guarded player
// writes and a one-group-per-cycle solved/conflict scanner.
module sudoku_board_dp
    import sudoku_pkg::*;
#(
    parameter  int BOX   = 2,
    localparam int N     = BOX * BOX,
    localparam int CELLS = N * N,
    localparam int VW    = vw_of(BOX),
    localparam int IW    = iw_of(BOX),
    localparam int EW    = ew_of(BOX)
) (
    input  logic                clka,
    input  logic                restart_n,
    input  logic                load_start,
    input  logic                load_valid,
    input  logic [VW-1:0]       load_val,
    input  logic                wr_valid,
    input  logic [IW-1:0]       wr_idx,
    input  logic [VW-1:0]       wr_val,
    output logic                wr_ready,
    output logic                wr_reject,
    input  logic                check_req,
    output logic                busy,
    output logic                done,
    output logic                solved,
    output logic [EW-1:0]       err_count,
    output logic [CELLS-1:0]    fill_flag,
    output logic [CELLS-1:0]    fixed_mask,
    output logic [CELLS*VW-1:0] board
);

    localparam int             GROUPS  = 3 * N;
    localparam int             GW      = $clog2(GROUPS);
    localparam logic [GW-1:0]  G_LAST  = GW'(GROUPS - 1);
    localparam logic [IW-1:0]  LD_LAST = IW'(CELLS - 1);
    localparam logic [VW-1:0]  VMAX    = VW'(N);

    // Assertion is asynchronous; release is re-timed to clka.
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) rst_pipe <= '0;
        else            rst_pipe <= {rst_pipe[0], 1'b1};
    end

    always_comb rst_n = rst_pipe[1];

    state_t          state;
    state_t          state_nxt;
    logic [VW-1:0]   cells [CELLS];
    logic [IW-1:0]   ld_cnt;
    logic [GW-1:0]   g;
    logic [EW-1:0]   dup_acc;
    logic [EW-1:0]   dup_sum;
    logic            full_acc;
    logic [N*VW-1:0] grp_vals;
    logic            grp_dup;
    logic            grp_full;
    logic            idx_ok;
    logic            wr_bad;
    logic [VW-1:0]   ld_val_s;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                wr_ready = 1'b1;
                if (load_start)     state_nxt = ST_LOAD;
                else if (check_req) state_nxt = ST_CHECK;
            end
            ST_LOAD: begin
                busy = 1'b1;
                if (load_start)                            state_nxt = ST_LOAD;
                else if (load_valid && ld_cnt == LD_LAST)  state_nxt = ST_IDLE;
            end
            ST_CHECK: begin
                busy = 1'b1;
                if (load_start)       state_nxt = ST_LOAD;
                else if (g == G_LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    if (CELLS == (1 << IW)) begin : g_idx_full
        always_comb idx_ok = 1'b1;
    end else begin : g_idx_part
        always_comb idx_ok = (wr_idx < IW'(CELLS));
    end

    always_comb begin
        wr_bad   = !idx_ok || (wr_val > VMAX) || fixed_mask[wr_idx];
        ld_val_s = (load_val > VMAX) ? '0 : load_val;
    end

    // Group member selection: constant cell map per group, muxed by g.
    always_comb begin
        grp_vals = '0;
        for (int unsigned gi = 0; gi < GROUPS; gi++) begin
            if (g == GW'(gi)) begin
                for (int unsigned k = 0; k < N; k++) begin
                    grp_vals[k*VW +: VW] = cells[group_cell(BOX, gi, k)];
                end
            end
        end
    end

    sudoku_group_check #(.BOX(BOX)) u_group_check (
        .vals (grp_vals),
        .dup  (grp_dup),
        .full (grp_full)
    );

    always_comb dup_sum = dup_acc + EW'(grp_dup);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            cells      <= '{default: '0};
            fixed_mask <= '0;
            ld_cnt     <= '0;
            g          <= '0;
            dup_acc    <= '0;
            full_acc   <= 1'b0;
            err_count  <= '0;
            solved     <= 1'b0;
            done       <= 1'b0;
            wr_reject  <= 1'b0;
        end else begin
            done      <= 1'b0;
            wr_reject <= 1'b0;
            if (load_start) begin
                cells      <= '{default: '0};
                fixed_mask <= '0;
                solved     <= 1'b0;
                err_count  <= '0;
                ld_cnt     <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (wr_valid) begin
                            if (wr_bad) begin
                                wr_reject <= 1'b1;
                            end else begin
                                cells[wr_idx] <= wr_val;
                                solved        <= 1'b0;
                            end
                        end
                        if (check_req) begin
                            g        <= '0;
                            dup_acc  <= '0;
                            full_acc <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (load_valid) begin
                            cells[ld_cnt]      <= ld_val_s;
                            fixed_mask[ld_cnt] <= (ld_val_s != '0);
                            ld_cnt             <= ld_cnt + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        g        <= g + 1'b1;
                        dup_acc  <= dup_sum;
                        full_acc <= full_acc & grp_full;
                        if (g == G_LAST) begin
                            err_count <= dup_sum;
                            solved    <= (dup_sum == '0) && full_acc && grp_full;
                            done      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        board     = '0;
        fill_flag = '0;
        for (int unsigned i = 0; i < CELLS; i++) begin
            board[i*VW +: VW] = cells[i];
            fill_flag[i]      = (cells[i] != '0);
        end
    end

endmodule

// File: tb/tb_sudoku_board_dp.sv
// Bench for sudoku_board_dp (BOX=2): write-vector table, directed multi-cycle
// cases and randomized loads/writes/scans against a board-level model.
module tb_sudoku_board_dp;

    localparam int BOX   = 2;
    localparam int N     = 4;
    localparam int CELLS = 16;
    localparam int VW    = 3;
    localparam int IW    = 4;
    localparam int EW    = 4;

    logic                clka       = 1'b0;
    logic                restart_n  = 1'b1;
    logic                load_start = 1'b0;
    logic                load_valid = 1'b0;
    logic [VW-1:0]       load_val   = '0;
    logic                wr_valid   = 1'b0;
    logic [IW-1:0]       wr_idx     = '0;
    logic [VW-1:0]       wr_val     = '0;
    logic                check_req  = 1'b0;
    logic                wr_ready;
    logic                wr_reject;
    logic                busy;
    logic                done;
    logic                solved;
    logic [EW-1:0]       err_count;
    logic [CELLS-1:0]    fill_flag;
    logic [CELLS-1:0]    fixed_mask;
    logic [CELLS*VW-1:0] board;

    int vectors     = 0;
    int miscompares = 0;

    int m_board [CELLS];
    bit m_fixed [CELLS];
    bit m_solved;
    int m_err;

    always #5 clka = ~clka;

    sudoku_board_dp #(.BOX(BOX)) dut (
        .clka       (clka),
        .restart_n  (restart_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_val   (load_val),
        .wr_valid   (wr_valid),
        .wr_idx     (wr_idx),
        .wr_val     (wr_val),
        .wr_ready   (wr_ready),
        .wr_reject  (wr_reject),
        .check_req  (check_req),
        .busy       (busy),
        .done       (done),
        .solved     (solved),
        .err_count  (err_count),
        .fill_flag  (fill_flag),
        .fixed_mask (fixed_mask),
        .board      (board)
    );

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [CELLS*VW-1:0] m_pack();
        logic [CELLS*VW-1:0] r;
        r = '0;
        for (int i = 0; i < CELLS; i++) r[i*VW +: VW] = VW'(m_board[i]);
        return r;
    endfunction

    function automatic logic [CELLS-1:0] m_fixmask();
        logic [CELLS-1:0] r;
        for (int i = 0; i < CELLS; i++) r[i] = m_fixed[i];
        return r;
    endfunction

    function automatic logic [CELLS-1:0] m_fill();
        logic [CELLS-1:0] r;
        for (int i = 0; i < CELLS; i++) r[i] = (m_board[i] != 0);
        return r;
    endfunction

    function automatic bit has_dup(input int v[N]);
        int c;
        for (int d = 1; d <= N; d++) begin
            c = 0;
            for (int k = 0; k < N; k++) if (v[k] == d) c++;
            if (c > 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Sudoku rules applied directly to the model board.
    function automatic void m_eval(output int errs, output bit ok);
        int v[N];
        int k;
        bit blank;
        errs  = 0;
        blank = 1'b0;
        for (int i = 0; i < CELLS; i++) if (m_board[i] == 0) blank = 1'b1;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) v[c] = m_board[r*N + c];
            if (has_dup(v)) errs++;
        end
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < N; r++) v[r] = m_board[r*N + c];
            if (has_dup(v)) errs++;
        end
        for (int br = 0; br < BOX; br++) begin
            for (int bc = 0; bc < BOX; bc++) begin
                k = 0;
                for (int r = 0; r < BOX; r++) begin
                    for (int c = 0; c < BOX; c++) begin
                        v[k] = m_board[(br*BOX + r)*N + bc*BOX + c];
                        k++;
                    end
                end
                if (has_dup(v)) errs++;
            end
        end
        ok = (errs == 0) && !blank;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < CELLS; i++) begin
            m_board[i] = 0;
            m_fixed[i] = 1'b0;
        end
        m_solved = 1'b0;
        m_err    = 0;
    endfunction

    task automatic check_state(input string tag);
        cmp({tag, "_board"},  board,      m_pack());
        cmp({tag, "_fixed"},  fixed_mask, m_fixmask());
        cmp({tag, "_fill"},   fill_flag,  m_fill());
        cmp({tag, "_solved"}, solved,     m_solved);
        cmp({tag, "_err"},    err_count,  m_err);
    endtask

    task automatic do_load(input int vals[CELLS], input bit gaps);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        m_clear();
        cmp("load_busy_start", busy, 1);
        for (int i = 0; i < CELLS; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            load_valid = 1'b1;
            load_val   = VW'(vals[i]);
            tick();
            load_valid = 1'b0;
            m_board[i] = (vals[i] > N) ? 0 : vals[i];
            m_fixed[i] = (m_board[i] != 0);
            if (i == CELLS - 2) cmp("load_busy_mid", busy, 1);
        end
        cmp("load_busy_end", busy, 0);
        check_state("load");
    endtask

    task automatic do_write(input int idx, input int val, output bit seen);
        bit rej;
        wr_valid = 1'b1;
        wr_idx   = IW'(idx);
        wr_val   = VW'(val);
        tick();
        wr_valid = 1'b0;
        rej = m_fixed[idx] || (val > N);
        if (!rej) begin
            m_board[idx] = val;
            m_solved     = 1'b0;
        end
        seen = wr_reject;
        cmp("wr_reject", wr_reject, rej);
        check_state("write");
        tick();
        cmp("wr_reject_pulse", wr_reject, 0);
    endtask

    task automatic do_check(input string name, input bit with_wr, input int idx, input int val);
        int lat;
        bit got;
        int e;
        bit ok;
        check_req = 1'b1;
        if (with_wr) begin
            wr_valid = 1'b1;
            wr_idx   = IW'(idx);
            wr_val   = VW'(val);
        end
        tick();
        check_req = 1'b0;
        wr_valid  = 1'b0;
        if (with_wr && !(m_fixed[idx] || val > N)) begin
            m_board[idx] = val;
            m_solved     = 1'b0;
        end
        cmp({name, "_busy"}, busy, 1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            if (done) got = 1'b1;
        end
        cmp({name, "_latency"}, lat, 3*N);
        m_eval(e, ok);
        m_err    = e;
        m_solved = ok;
        check_state(name);
        tick();
        cmp({name, "_done_pulse"}, done, 0);
        cmp({name, "_idle"},       busy, 0);
    endtask

    typedef struct {
        int idx;
        int val;
        bit exp_rej;
        bit scan;
        int exp_err;
        bit exp_solved;
    } wvec_t;

    initial begin
        wvec_t tbl[7];
        int    puzzle[CELLS];
        int    sol[CELLS];
        int    vals[CELLS];
        int    idx;
        int    val;
        bit    seen;
        bit    saw_done;

        puzzle = '{1,0,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};
        sol    = '{1,2,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};

        tbl[0] = '{0, 2, 1'b1, 1'b0, 0, 1'b0};
        tbl[1] = '{1, 5, 1'b1, 1'b1, 0, 1'b0};
        tbl[2] = '{1, 2, 1'b0, 1'b1, 0, 1'b1};
        tbl[3] = '{1, 1, 1'b0, 1'b1, 3, 1'b0};
        tbl[4] = '{1, 0, 1'b0, 1'b1, 0, 1'b0};
        tbl[5] = '{3, 1, 1'b1, 1'b0, 0, 1'b0};
        tbl[6] = '{1, 2, 1'b0, 1'b1, 0, 1'b1};

        // Power-on reset.
        #2 restart_n = 1'b0;
        #1;
        m_clear();
        check_state("reset");
        cmp("reset_busy",     busy,      0);
        cmp("reset_done",     done,      0);
        cmp("reset_wr_ready", wr_ready,  1);
        cmp("reset_reject",   wr_reject, 0);
        repeat (2) tick();
        restart_n = 1'b1;
        repeat (3) tick();

        // Puzzle load and the write/scan table.
        do_load(puzzle, 1'b0);
        cmp("puzzle_fixed", fixed_mask, 16'hFFFD);
        for (int t = 0; t < 7; t++) begin
            do_write(tbl[t].idx, tbl[t].val, seen);
            cmp("tbl_reject", seen, tbl[t].exp_rej);
            if (tbl[t].scan) begin
                do_check("tbl_scan", 1'b0, 0, 0);
                cmp("tbl_err",    err_count, tbl[t].exp_err);
                cmp("tbl_solved", solved,    tbl[t].exp_solved);
            end
        end
        cmp("solved_fill", fill_flag, 16'hFFFF);

        // Abort a scan at g=7 with load_start.
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
        repeat (7) tick();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        m_clear();
        cmp("abort_busy",     busy,     1);
        cmp("abort_wr_ready", wr_ready, 0);
        check_state("abort");
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        cmp("abort_no_done", saw_done, 0);
        cmp("abort_in_load", busy,     1);

        // Reload, then write and scan on the same edge.
        do_load(puzzle, 1'b1);
        do_check("same_edge", 1'b1, 1, 2);
        cmp("same_edge_solved", solved,    1);
        cmp("same_edge_err",    err_count, 0);

        // Reset at g=5 of a scan.
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
        repeat (5) tick();
        restart_n = 1'b0;
        #1;
        m_clear();
        check_state("rst_mid");
        cmp("rst_mid_busy",     busy,     0);
        cmp("rst_mid_wr_ready", wr_ready, 1);
        cmp("rst_mid_done",     done,     0);
        saw_done = 1'b0;
        repeat (2) tick();
        restart_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        cmp("rst_mid_no_done", saw_done, 0);
        check_state("rst_mid_after");

        // Randomized loads, writes and scans.
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < CELLS; i++)
                vals[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : sol[i];
            do_load(vals, 1'b1);
            for (int w = 0; w < 12; w++) begin
                idx = $urandom_range(0, CELLS - 1);
                val = $urandom_range(0, 1) ? sol[idx] : int'($urandom_range(0, 7));
                do_write(idx, val, seen);
                if ($urandom_range(0, 2) == 0) do_check("rand_scan", 1'b0, 0, 0);
            end
            for (int i = 0; i < CELLS; i++) begin
                if (!m_fixed[i]) do_write(i, sol[i], seen);
            end
            do_check("rand_final", 1'b0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
